// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg: shared types and width helpers for the serial pattern
// transmitter.
//   state_t   : transmitter FSM states (IDLE, SHIFT, DONE)
//   len_width : width of the length port for a given maximum pattern length
//   cnt_width : prescaler counter width for a given bit period (never 0)
package seq_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int len_width(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

  // DIV=1 still needs a 1-bit counter so the vector is never zero-width.
  function automatic int cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seq_gen_bit_prescaler.sv
// bit_prescaler: DIV-cycle tick generator that paces the serial bits.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   clr   : synchronous clear, counter returns to 0
//   en    : count enable
//   tick  : high on the cycle the counter wraps from DIV-1 to 0
// With DIV=1 the counter is stuck at 0 and tick follows en every cycle.
module bit_prescaler
  import seq_gen_pkg::*;
#(
  parameter int DIV = 1,
  parameter int CW  = cnt_width(DIV)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(DIV - 1));
  assign tick = en & wrap;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= wrap ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/seq_gen.sv
// seq_gen: serial pattern transmitter feeding the sequence detector's P1
// input. A pattern of 1..PAT_W bits is captured on start (IDLE only) and
// shifted out MSB-first, each bit held DIV clocks, followed by a one-cycle
// DONE state.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset, aborts any transfer
//   start   : transmit request, sampled only in IDLE
//   loop    : (SEQ_GEN_LOOP_EN only) repeat the captured pattern seamlessly
//   pattern : bits to send, the low len bits are used
//   len     : bit count, clamped to PAT_W
//   P1      : registered serial data (0 outside SHIFT)
//   valid   : P1 carries a pattern bit
//   busy    : high in SHIFT and DONE
//   done    : one-cycle pulse after the last bit
// Optional feature macro: SEQ_GEN_LOOP_EN (adds loop port and a captured copy
// of the aligned pattern and length for restarting).
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = 12,
  parameter int DIV   = 1,
  parameter int LEN_W = len_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_GEN_LOOP_EN
  input  logic             loop,
`endif
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             P1,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nx;
  logic [PAT_W-1:0] sreg, sreg_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic [LEN_W-1:0] eff_len;
  logic [PAT_W-1:0] aligned;
  logic             p1_nx, valid_nx, busy_nx, done_nx;
  logic             tick, shifting;
`ifdef SEQ_GEN_LOOP_EN
  logic [PAT_W-1:0] copy, copy_nx;
  logic [LEN_W-1:0] lenq, lenq_nx;
`endif

  // Clamp so the bit counter can never be loaded past PAT_W.
  assign eff_len = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;

  // Left-align the low eff_len bits so pattern[L-1] sits at the shift
  // register MSB; every bit is then taken from the same MSB position.
  assign aligned = pattern << (LEN_W'(PAT_W) - eff_len);

  assign shifting = (state == SHIFT);

  // Prescaler is held clear outside SHIFT, so its count is 0 right after the
  // start edge and the first wrap lands exactly DIV cycles later.
  bit_prescaler #(.DIV(DIV)) u_pre (
    .clk   (clk),
    .reset (reset),
    .clr   (!shifting),
    .en    (shifting),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      P1    <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_GEN_LOOP_EN
      copy  <= '0;
      lenq  <= '0;
`endif
    end else begin
      state <= state_nx;
      sreg  <= sreg_nx;
      cnt   <= cnt_nx;
      P1    <= p1_nx;
      valid <= valid_nx;
      busy  <= busy_nx;
      done  <= done_nx;
`ifdef SEQ_GEN_LOOP_EN
      copy  <= copy_nx;
      lenq  <= lenq_nx;
`endif
    end
  end

  // Outputs are computed one cycle ahead so they come straight from flops.
  always_comb begin
    state_nx = state;
    sreg_nx  = sreg;
    cnt_nx   = cnt;
    p1_nx    = 1'b0;
    valid_nx = 1'b0;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
`ifdef SEQ_GEN_LOOP_EN
    copy_nx  = copy;
    lenq_nx  = lenq;
`endif
    unique case (state)
      IDLE: begin
        if (start) begin
          sreg_nx = aligned;
          cnt_nx  = eff_len;
          busy_nx = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
          copy_nx = aligned;
          lenq_nx = eff_len;
`endif
          if (eff_len == '0) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            state_nx = SHIFT;
            p1_nx    = aligned[PAT_W-1];
            valid_nx = 1'b1;
          end
        end
      end

      SHIFT: begin
        busy_nx  = 1'b1;
        valid_nx = 1'b1;
        p1_nx    = sreg[PAT_W-1];
        if (tick) begin
          if (cnt == LEN_W'(1)) begin
`ifdef SEQ_GEN_LOOP_EN
            if (loop) begin
              // Seamless restart: reload from the captured copy, prescaler
              // keeps running so there is no gap cycle.
              sreg_nx = copy;
              cnt_nx  = lenq;
              p1_nx   = copy[PAT_W-1];
            end else begin
`endif
              state_nx = DONE;
              valid_nx = 1'b0;
              p1_nx    = 1'b0;
              done_nx  = 1'b1;
`ifdef SEQ_GEN_LOOP_EN
            end
`endif
          end else begin
            sreg_nx = {sreg[PAT_W-2:0], 1'b0};
            cnt_nx  = cnt - LEN_W'(1);
            p1_nx   = sreg[PAT_W-2];
          end
        end
      end

      DONE: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// tb_seq_gen: scoreboard bench for seq_gen. Two instances (DIV=1, DIV=3)
// share clock and reset. Each transmission pushes its expected bit stream
// (each bit repeated DIV times) and expected done cycle into queues; a
// negedge monitor pops and compares whenever valid or done is presented.
module tb_seq_gen;

  localparam int PAT_W = 12;
  localparam int LEN_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start1 = 1'b0, start3 = 1'b0;
  logic loop1 = 1'b0, loop3 = 1'b0;
  logic [PAT_W-1:0] pat1 = '0, pat3 = '0;
  logic [LEN_W-1:0] len1 = '0, len3 = '0;
  logic p1_1, valid1, busy1, done1;
  logic p1_3, valid3, busy3, done3;

  int   cyc = 0;
  int   errs = 0;
  int   checks = 0;
  int   q1[$], q3[$];
  int   dq1[$], dq3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_gen #(.PAT_W(PAT_W), .DIV(1)) u_d1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef SEQ_GEN_LOOP_EN
    .loop(loop1),
`endif
    .pattern(pat1), .len(len1),
    .P1(p1_1), .valid(valid1), .busy(busy1), .done(done1)
  );

  seq_gen #(.PAT_W(PAT_W), .DIV(3)) u_d3 (
    .clk(clk), .reset(reset), .start(start3),
`ifdef SEQ_GEN_LOOP_EN
    .loop(loop3),
`endif
    .pattern(pat3), .len(len3),
    .P1(p1_3), .valid(valid3), .busy(busy3), .done(done3)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic p, input logic v,
                     input logic b, input logic dn);
    int e;
    chk(d ? "d3_busy" : "d1_busy", int'(b), int'(v | dn));
    if (v) begin
      e = -1;
      if (d == 0 && q1.size() > 0) e = q1.pop_front();
      if (d == 1 && q3.size() > 0) e = q3.pop_front();
      chk(d ? "d3_bit" : "d1_bit", int'(p), e);
    end else begin
      chk(d ? "d3_idle_p1" : "d1_idle_p1", int'(p), 0);
    end
    if (dn) begin
      e = -1;
      if (d == 0 && dq1.size() > 0) e = dq1.pop_front();
      if (d == 1 && dq3.size() > 0) e = dq3.pop_front();
      chk(d ? "d3_done_cycle" : "d1_done_cycle", cyc, e);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon(0, p1_1, valid1, busy1, done1);
      mon(1, p1_3, valid3, busy3, done3);
    end
  end

  // Reference model: L = min(len, PAT_W); bits pattern[L-1]..pattern[0] each
  // seen DIV times; done observed L*DIV cycles after the start edge.
  task automatic expect_xfer(input int d, input logic [PAT_W-1:0] pat,
                             input int L, input int passes, input int e0);
    int dv;
    dv = d ? 3 : 1;
    for (int p = 0; p < passes; p++)
      for (int k = L - 1; k >= 0; k--)
        for (int r = 0; r < dv; r++)
          if (d == 0) q1.push_back(int'(pat[k])); else q3.push_back(int'(pat[k]));
    if (d == 0) dq1.push_back(e0 + L * passes * dv);
    else        dq3.push_back(e0 + L * passes * dv);
  endtask

  task automatic send(input int d, input logic [PAT_W-1:0] pat,
                      input logic [LEN_W-1:0] ln, input bit wt, input bit mid);
    int L, dv;
    L  = (int'(ln) > PAT_W) ? PAT_W : int'(ln);
    dv = d ? 3 : 1;
    @(negedge clk);
    if (d == 0) begin pat1 = pat; len1 = ln; start1 = 1'b1; end
    else        begin pat3 = pat; len3 = ln; start3 = 1'b1; end
    expect_xfer(d, pat, L, 1, cyc + 1);
    @(posedge clk); #1;
    start1 = 1'b0; start3 = 1'b0;
    // Scramble inputs after capture; they must not affect the transfer.
    pat1 = PAT_W'($urandom); len1 = LEN_W'($urandom);
    pat3 = PAT_W'($urandom); len3 = LEN_W'($urandom);
    if (wt) begin
      for (int c = 0; c < L * dv + 1; c++) begin
        if (d == 0) start1 = mid; else start3 = mid;
        @(posedge clk); #1;
      end
      start1 = 1'b0; start3 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: nothing must be sent.
    start1 = 1'b1; start3 = 1'b1;
    #11;
    chk("rst_p1",    int'(p1_1),  0);
    chk("rst_valid", int'(valid1), 0);
    chk("rst_busy",  int'(busy3), 0);
    chk("rst_done",  int'(done3), 0);
    #1;
    start1 = 1'b0; start3 = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_busy1", int'(busy1), 0);
      chk("post_rst_busy3", int'(busy3), 0);
    end

    // Directed cases.
    send(0, 12'hB9A, 4'd12, 1'b1, 1'b0);
    send(1, 12'h009, 4'd4,  1'b1, 1'b1);   // start held mid-transfer, ignored
    send(0, 12'h5A5, 4'd0,  1'b1, 1'b0);   // len=0: done only
    send(1, 12'hFFF, 4'd0,  1'b1, 1'b0);
    send(0, 12'hC3E, 4'd15, 1'b1, 1'b0);   // clamped to 12 bits
    send(1, 12'h8F1, 4'd13, 1'b1, 1'b0);
    send(0, 12'h001, 4'd1,  1'b1, 1'b0);
    send(1, 12'h002, 4'd2,  1'b1, 1'b1);

    // Async reset during bit 5 of 12: abort, no done.
    send(0, 12'hB9A, 4'd12, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_p1",    int'(p1_1),   0);
    chk("abort_valid", int'(valid1), 0);
    chk("abort_busy",  int'(busy1),  0);
    chk("abort_done",  int'(done1),  0);
    q1.delete(); dq1.delete();
    @(negedge clk); #2;
    reset = 1'b1;
    send(0, 12'hB9A, 4'd12, 1'b1, 1'b0);

    // Randomised transfers on both instances.
    for (int i = 0; i < 24; i++) begin
      send(i % 2, PAT_W'($urandom), LEN_W'($urandom_range(0, 15)), 1'b1,
           1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

`ifdef SEQ_GEN_LOOP_EN
    // Loop: 110 repeated; loop dropped during the third pass.
    @(negedge clk);
    pat1 = 12'b110; len1 = 4'd3; loop1 = 1'b1; start1 = 1'b1;
    expect_xfer(0, 12'b110, 3, 3, cyc + 1);
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    loop1 = 1'b0;
    repeat (6) @(posedge clk);
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("d1_bits_left", q1.size(),  0);
    chk("d3_bits_left", q3.size(),  0);
    chk("d1_done_left", dq1.size(), 0);
    chk("d3_done_left", dq3.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
